// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready producer interface feeding the UART transmit FIFO.
//   s_data  : word to transmit (DATA_BITS wide)
//   s_valid : producer has a word on s_data
//   s_ready : FIFO can accept; a word moves on any edge with s_valid && s_ready
// master = producer side, slave = the uart_tx_fifo side.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated transmit FIFO and baud divider.
// Words pushed through the valid/ready interface are queued and sent as
// start / DATA_BITS (LSB first) / [parity] / STOP_BITS frames, back to back
// while the FIFO holds data.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-low reset
//   s_if       : uart_tx_fifo_if.slave (s_data, s_valid, s_ready)
//   tx         : serial line, idle high, registered
//   tx_busy    : high whenever the FSM is not idle
//   fifo_count : words currently stored in the FIFO
//
// Configuration macro: UART_TX_PARITY_EN inserts a parity bit after the data
// bits (even, or odd when PARITY_ODD = 1). Without it the frame carries no
// parity and PARITY_ODD has no effect.
module uart_tx_fifo #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int PARITY_ODD    = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_fifo_if.slave               s_if,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int DIV   = (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = 4;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // Elaboration-time guard against parameter sets the datapath cannot honour.
    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1) || DIV < 1) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Parity of a payload word; odd = 1 inverts the even-parity result.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic                 parity_r;
`endif

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    state_t               state_r;
    logic [DIV_W-1:0]     div_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 tx_r;
    logic                 busy_r;

    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 bit_end_s;
    logic                 frame_end_s;
    logic [DATA_BITS-1:0] head_s;

    // FIFO status and handshake decode; pops happen only when a frame may start.
    always_comb begin
        full_s      = (count_r == FULL_COUNT);
        empty_s     = (count_r == '0);
        push_s      = s_if.s_valid && !full_s;
        bit_end_s   = (div_r == DIV_LAST);
        frame_end_s = (state_r == ST_STOP) && bit_end_s && (bit_cnt_r == STOP_LAST);
        head_s      = mem_r[rd_ptr_r];
        if (empty_s) begin
            pop_s = 1'b0;
        end else begin
            pop_s = (state_r == ST_IDLE) || frame_end_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_if.s_data;
        end
    end

    // FIFO pointers and occupancy; a full FIFO refuses a push even on a pop cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame FSM with baud divider; tx and tx_busy are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            div_r     <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            // Divider idles at zero and wraps every bit time, so a frame
            // entered from IDLE or straight from STOP starts at phase zero.
            if (state_r == ST_IDLE || bit_end_s) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r   <= ST_START;
                        shift_r   <= head_s;
                        bit_cnt_r <= '0;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_r  <= calc_parity(head_s, 1'(PARITY_ODD));
`endif
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        tx_r      <= shift_r[0];
                        shift_r   <= shift_r >> 1;
                        bit_cnt_r <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_cnt_r == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_r   <= ST_PARITY;
                            tx_r      <= parity_r;
`else
                            state_r   <= ST_STOP;
                            tx_r      <= 1'b1;
`endif
                            bit_cnt_r <= '0;
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r   <= ST_STOP;
                        tx_r      <= 1'b1;
                        bit_cnt_r <= '0;
                    end
                end
`endif
                ST_STOP: begin
                    if (frame_end_s) begin
                        // Chain straight into the next start bit when data waits.
                        if (pop_s) begin
                            state_r   <= ST_START;
                            shift_r   <= head_s;
                            bit_cnt_r <= '0;
                            tx_r      <= 1'b0;
                            busy_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                            parity_r  <= calc_parity(head_s, 1'(PARITY_ODD));
`endif
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else if (bit_end_s) begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // s_ready depends on the stored count only, never on s_valid.
    assign s_if.s_ready = ~full_s;
    assign tx           = tx_r;
    assign tx_busy      = busy_r;
    assign fifo_count   = count_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo at DIV = 10.
// dut_a: 8 data bits, 1 stop, depth 4, even parity option.
// dut_b: 7 data bits, 2 stop, depth 4, odd parity option.
// A line monitor per DUT decodes frames from tx into capture queues; tests
// push expected words when the word is accepted and compare on capture.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int DIV    = 10;
    localparam int FLEN_A = (1 + 8 + PB + 1) * DIV;
    localparam int FLEN_B = (1 + 7 + PB + 2) * DIV;

    typedef struct {
        logic [8:0] data;
        bit         ok;
        int         start;
    } cap_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       tx_a, busy_a, tx_b, busy_b;
    logic [2:0] cnt_a, cnt_b;

    cap_t       cap_a[$];
    cap_t       cap_b[$];
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];

    uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if_b ();

    uart_tx_fifo #(
        .CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .reset(reset), .s_if(if_a),
        .tx(tx_a), .tx_busy(busy_a), .fifo_count(cnt_a)
    );

    uart_tx_fifo #(
        .CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
        .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1)
    ) dut_b (
        .clk(clk), .reset(reset), .s_if(if_b),
        .tx(tx_b), .tx_busy(busy_b), .fifo_count(cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic tx_of(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic ref_par(input logic [8:0] d, input int nb, input int odd);
        logic p;
        p = (odd != 0);
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        return p;
    endfunction

    // Expected line level k cycles after the start bit began.
    function automatic logic exp_bit(input int k, input logic [8:0] d, input int nb, input int odd);
        int b;
        b = k / DIV;
        if (b == 0) return 1'b0;
        if (b <= nb) return d[b-1];
        if (PB == 1 && b == nb + 1) return ref_par(d, nb, odd);
        return 1'b1;
    endfunction

    // Line monitor: decodes frames, checks each bit is stable for DIV cycles.
    task automatic monitor(input int w);
        cap_t c;
        logic bv;
        bit   abort;
        int   nb, sb, odd;
        nb  = (w == 0) ? 8 : 7;
        sb  = (w == 0) ? 1 : 2;
        odd = (w == 0) ? 0 : 1;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx_of(w) === 1'b0) begin
                c.start = cyc; c.ok = 1'b1; c.data = '0; abort = 1'b0; bv = 1'b0;
                for (int s = 0; s < 1 + nb + PB + sb; s++) begin
                    for (int j = 0; j < DIV; j++) begin
                        if (!(s == 0 && j == 0)) @(negedge clk);
                        if (reset !== 1'b1) abort = 1'b1;
                        if (j == 0) begin
                            bv = tx_of(w);
                            if (s == 0) begin
                                if (bv !== 1'b0) c.ok = 1'b0;
                            end else if (s <= nb) begin
                                c.data[s-1] = bv;
                            end else if (PB == 1 && s == nb + 1) begin
                                if (bv !== ref_par(c.data, nb, odd)) c.ok = 1'b0;
                            end else if (bv !== 1'b1) begin
                                c.ok = 1'b0;
                            end
                        end else if (tx_of(w) !== bv) begin
                            c.ok = 1'b0;
                        end
                    end
                end
                if (!abort) begin
                    if (w == 0) cap_a.push_back(c);
                    else cap_b.push_back(c);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Walks a frame from its first start-bit cycle until tx_busy drops.
    task automatic measure(input int w, input logic [8:0] d, output int errs, output int len);
        int nb, odd;
        nb = (w == 0) ? 8 : 7;
        odd = (w == 0) ? 0 : 1;
        errs = 0; len = 0;
        while (busy_of(w) === 1'b1 && len < 400) begin
            if (tx_of(w) !== exp_bit(len, d, nb, odd)) errs++;
            len++;
            @(negedge clk);
        end
    endtask

    // Pulls one captured frame and its expected word (no comparison here).
    task automatic fetch(input int w, output bit got, output cap_t c, output logic [8:0] e);
        got = 1'b0; c.data = '0; c.ok = 1'b0; c.start = 0; e = '0;
        for (int i = 0; i < 40; i++) begin
            if (((w == 0) ? cap_a.size() : cap_b.size()) > 0) break;
            @(negedge clk);
        end
        if (w == 0) begin
            if (cap_a.size() > 0 && exp_a.size() > 0) begin
                c = cap_a.pop_front(); e = exp_a.pop_front(); got = 1'b1;
            end
        end else begin
            if (cap_b.size() > 0 && exp_b.size() > 0) begin
                c = cap_b.pop_front(); e = exp_b.pop_front(); got = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (tx_a !== 1'b1 || tx_b !== 1'b1) begin n_bad++; $display("FAIL reset_tx: a=%b b=%b want 1", tx_a, tx_b); end
        n_cmp++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy: a=%b b=%b want 0", busy_a, busy_b); end
        n_cmp++; if (if_a.s_ready !== 1'b1 || if_b.s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: a=%b b=%b want 1", if_a.s_ready, if_b.s_ready); end
        n_cmp++; if (cnt_a !== 3'd0 || cnt_b !== 3'd0) begin n_bad++; $display("FAIL reset_count: a=%0d b=%0d want 0", cnt_a, cnt_b); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int errs, len; bit got; cap_t c; logic [8:0] e;
        if_a.s_data = 8'hA5; if_a.s_valid = 1'b1;
        if (if_a.s_ready === 1'b1) exp_a.push_back(9'h0A5);
        @(negedge clk);
        if_a.s_valid = 1'b0;
        n_cmp++; if (cnt_a !== 3'd1 || busy_a !== 1'b0 || tx_a !== 1'b1) begin n_bad++; $display("FAIL single_accept: count=%0d busy=%b tx=%b want 1/0/1", cnt_a, busy_a, tx_a); end
        @(negedge clk);
        n_cmp++; if (tx_a !== 1'b0 || busy_a !== 1'b1 || cnt_a !== 3'd0) begin n_bad++; $display("FAIL single_start: tx=%b busy=%b count=%0d want 0/1/0", tx_a, busy_a, cnt_a); end
        measure(0, 9'h0A5, errs, len);
        n_cmp++; if (len != FLEN_A) begin n_bad++; $display("FAIL single_busy_len: got %0d want %0d", len, FLEN_A); end
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL single_bit_timing: %0d bad cycles want 0", errs); end
        fetch(0, got, c, e);
        n_cmp++; if (!got || c.data !== e || !c.ok) begin n_bad++; $display("FAIL single_sb: got=%b data=%h ok=%b want %h", got, c.data, c.ok, e); end
    endtask

    task automatic test_7e2();
        int errs, len; bit got; cap_t c; logic [8:0] e;
        @(negedge clk);
        if_b.s_data = 7'h55; if_b.s_valid = 1'b1;
        if (if_b.s_ready === 1'b1) exp_b.push_back(9'h055);
        @(negedge clk);
        if_b.s_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx_b !== 1'b0 || busy_b !== 1'b1) begin n_bad++; $display("FAIL b_start: tx=%b busy=%b want 0/1", tx_b, busy_b); end
        measure(1, 9'h055, errs, len);
        n_cmp++; if (len != FLEN_B) begin n_bad++; $display("FAIL b_busy_len: got %0d want %0d", len, FLEN_B); end
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL b_bit_timing: %0d bad cycles want 0", errs); end
        fetch(1, got, c, e);
        n_cmp++; if (!got || c.data !== e || !c.ok) begin n_bad++; $display("FAIL b_sb: got=%b data=%h ok=%b want %h", got, c.data, c.ok, e); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int k, nb; logic pbit; bit got; cap_t c; logic [8:0] e;
        for (int w = 0; w < 2; w++) begin
            nb = (w == 0) ? 8 : 7;
            @(negedge clk);
            if (w == 0) begin
                if_a.s_data = 8'h07; if_a.s_valid = 1'b1;
                if (if_a.s_ready === 1'b1) exp_a.push_back(9'h007);
            end else begin
                if_b.s_data = 7'h07; if_b.s_valid = 1'b1;
                if (if_b.s_ready === 1'b1) exp_b.push_back(9'h007);
            end
            @(negedge clk);
            if_a.s_valid = 1'b0; if_b.s_valid = 1'b0;
            @(negedge clk);
            k = 0; pbit = 1'bx;
            while (busy_of(w) === 1'b1 && k < 400) begin
                if (k == (1 + nb) * DIV + 5) pbit = tx_of(w);
                k++;
                @(negedge clk);
            end
            n_cmp++; if (pbit !== ((w == 0) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL parity_bit_%0d: got %b want %b", w, pbit, (w == 0) ? 1'b1 : 1'b0); end
            n_cmp++; if (k != ((w == 0) ? FLEN_A : FLEN_B)) begin n_bad++; $display("FAIL parity_len_%0d: got %0d", w, k); end
            fetch(w, got, c, e);
            n_cmp++; if (!got || c.data !== e || !c.ok) begin n_bad++; $display("FAIL parity_sb_%0d: data=%h ok=%b want %h", w, c.data, c.ok, e); end
        end
    endtask
`endif

    task automatic test_back_to_back();
        int idx, acc6, first_low, peak, t0, rel, prev;
        bit got; cap_t c; logic [8:0] e;
        idx = 1; acc6 = 0; first_low = -1; peak = 0; prev = 0;
        @(negedge clk);
        t0 = cyc;
        rel = 0;
        while (idx <= 6 && rel < 2000) begin
            rel = cyc - t0;
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
            if_a.s_data = 8'(idx); if_a.s_valid = 1'b1;
            if (if_a.s_ready === 1'b1) begin
                exp_a.push_back(9'(idx));
                if (rel < 6) acc6++;
                idx++;
            end else if (first_low < 0) begin
                first_low = rel;
            end
            @(negedge clk);
        end
        if_a.s_valid = 1'b0;
        for (int i = 0; i < 6 * FLEN_A + 300 && cap_a.size() < 6; i++) begin
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
            @(negedge clk);
        end
        n_cmp++; if (idx != 7) begin n_bad++; $display("FAIL b2b_all_accepted: next idx %0d want 7", idx); end
        n_cmp++; if (acc6 != 5) begin n_bad++; $display("FAIL b2b_accepted_in_6: got %0d want 5", acc6); end
        n_cmp++; if (first_low != 5) begin n_bad++; $display("FAIL b2b_ready_low_edge: got %0d want 5", first_low); end
        n_cmp++; if (peak != 4) begin n_bad++; $display("FAIL b2b_peak_count: got %0d want 4", peak); end
        for (int i = 0; i < 6; i++) begin
            fetch(0, got, c, e);
            n_cmp++; if (!got || c.data !== e || !c.ok) begin n_bad++; $display("FAIL b2b_sb_%0d: got=%b data=%h ok=%b want %h", i, got, c.data, c.ok, e); end
            if (i > 0) begin
                n_cmp++; if (c.start - prev != FLEN_A) begin n_bad++; $display("FAIL b2b_gap_%0d: spacing %0d want %0d", i, c.start - prev, FLEN_A); end
            end
            prev = c.start;
        end
    endtask

    task automatic test_busy_fall_push();
        int errs, len, k; bit got; cap_t c; logic [8:0] e;
        @(negedge clk);
        if_a.s_data = 8'h81; if_a.s_valid = 1'b1;
        if (if_a.s_ready === 1'b1) exp_a.push_back(9'h081);
        @(negedge clk);
        if_a.s_valid = 1'b0;
        @(negedge clk);
        k = 0;
        while (busy_a === 1'b1 && k < 400) begin
            if (k == FLEN_A - 1) begin
                if_a.s_data = 8'h3C; if_a.s_valid = 1'b1;
                if (if_a.s_ready === 1'b1) exp_a.push_back(9'h03C);
            end
            k++;
            @(negedge clk);
        end
        if_a.s_valid = 1'b0;
        n_cmp++; if (k != FLEN_A) begin n_bad++; $display("FAIL fall_first_len: got %0d want %0d", k, FLEN_A); end
        n_cmp++; if (busy_a !== 1'b0 || tx_a !== 1'b1 || cnt_a !== 3'd1) begin n_bad++; $display("FAIL fall_gap: busy=%b tx=%b count=%0d want 0/1/1", busy_a, tx_a, cnt_a); end
        @(negedge clk);
        n_cmp++; if (busy_a !== 1'b1 || tx_a !== 1'b0) begin n_bad++; $display("FAIL fall_restart: busy=%b tx=%b want 1/0", busy_a, tx_a); end
        measure(0, 9'h03C, errs, len);
        n_cmp++; if (len != FLEN_A || errs != 0) begin n_bad++; $display("FAIL fall_frame: len=%0d errs=%0d want %0d/0", len, errs, FLEN_A); end
        for (int i = 0; i < 2; i++) begin
            fetch(0, got, c, e);
            n_cmp++; if (!got || c.data !== e || !c.ok) begin n_bad++; $display("FAIL fall_sb_%0d: got=%b data=%h ok=%b want %h", i, got, c.data, c.ok, e); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0, capsz, busy_seen;
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            if_a.s_data = 8'(8'h11 + i); if_a.s_valid = 1'b1;
            @(negedge clk);
        end
        if_a.s_valid = 1'b0;
        n_cmp++; if (cnt_a !== 3'd3 || busy_a !== 1'b1) begin n_bad++; $display("FAIL rst_queued: count=%0d busy=%b want 3/1", cnt_a, busy_a); end
        while (cyc < t0 + 36) @(negedge clk);
        capsz = cap_a.size();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx: got %b want 1", tx_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy_a); end
        n_cmp++; if (cnt_a !== 3'd0) begin n_bad++; $display("FAIL rst_mid_count: got %0d want 0", cnt_a); end
        n_cmp++; if (if_a.s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", if_a.s_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || tx_a !== 1'b1) busy_seen++;
        end
        n_cmp++; if (busy_seen != 0) begin n_bad++; $display("FAIL rst_no_frames: %0d active cycles want 0", busy_seen); end
        n_cmp++; if (cap_a.size() != capsz) begin n_bad++; $display("FAIL rst_no_capture: %0d frames want %0d", cap_a.size(), capsz); end
    endtask

    task automatic test_drain();
        n_cmp++;
        if (exp_a.size() + exp_b.size() + cap_a.size() + cap_b.size() != 0) begin
            n_bad++;
            $display("FAIL drain: leftover exp=%0d/%0d cap=%0d/%0d want 0", exp_a.size(), exp_b.size(), cap_a.size(), cap_b.size());
        end
    endtask

    initial begin
        if_a.s_valid = 1'b0; if_a.s_data = '0;
        if_b.s_valid = 1'b0; if_b.s_data = '0;
        test_reset();
        test_single_frame();
        test_7e2();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_busy_fall_push();
        test_reset_mid_frame();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and baud divider. It is the next generation of the single-byte TX path and serialises coprocessor result words to the host link. The data width, stop-bit count, FIFO depth and optional parity are all configurable. A valid/ready producer interface replaces the start/busy pulse protocol, so software-side bursts no longer stall on every byte.

## Interface
- `CLK_FREQUENCY`, 100_000_000, system clock in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `DATA_BITS`, 8, payload bits per frame, legal 5..9
- `STOP_BITS`, 1, stop bits per frame, legal 1 or 2
- `FIFO_DEPTH`, 16, entries, power of two ≥ 2
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity (only used with parity compiled in)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `s_data`  in  DATA_BITS  word to transmit
- `s_valid`  in  1  producer has a word on `s_data`
- `s_ready`  out  1  FIFO can accept; a word transfers on any edge with `s_valid && s_ready`
- `tx`  out  1  serial line, idle high, registered
- `tx_busy`  out  1  high whenever the FSM is not in IDLE
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words currently stored

## Operation
- Baud divider: `DIV = (CLK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE`. The counter runs 0..DIV-1 only outside IDLE and is cleared on entry to START, so every bit lasts exactly DIV cycles with no phase error at frame start.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when FIFO not empty: pop the head word into the shift register; `tx` ← 0.
  - START → DATA after DIV cycles. DATA shifts LSB first for DATA_BITS bit times.
  - DATA → PARITY (parity compiled in) or STOP.
  - PARITY lasts one bit time. `tx` = XOR of the data bits, inverted when PARITY_ODD = 1.
  - STOP holds `tx` = 1 for STOP_BITS × DIV cycles. At the end: if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × DIV cycles, where P = 1 with parity, else 0.
- FIFO:
  - `s_ready` = !full.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count saturates at FIFO_DEPTH.
  - A push while full is not accepted, even if a pop occurs in the same cycle.
  - Pop never occurs while empty.
- Reset (`reset` = 0 at an edge), including mid-frame: FIFO emptied, `fifo_count` = 0, FSM → IDLE, divider = 0. The partial frame is abandoned and `tx` returns high on that edge.

## Timing
- Reset values: `tx` = 1, `tx_busy` = 0, `s_ready` = 1, `fifo_count` = 0.
- Latency:
  - Word accepted at edge N into an empty FIFO with the FSM idle: `fifo_count` = 1 after N.
  - Pop and START at edge N+1: `tx` falls and `tx_busy` rises after N+1.
- `tx_busy` falls on the edge that ends the last stop bit when the FIFO is empty. A push on that same edge is seen at the following edge, giving a one-cycle idle gap.
- `s_ready` is registered-equivalent: it depends on `fifo_count` only, never combinationally on `s_valid`.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state present, parity bit inserted per `PARITY_ODD`.
- Not defined: PARITY state and parity logic removed, frame is 1 + DATA_BITS + STOP_BITS bits, `PARITY_ODD` ignored.

## Test plan
All tests use CLK_FREQUENCY = 1_000_000 and BAUD_RATE = 100_000, so DIV = 10.

- 8N1, push 0xA5 once at edge 0 → `tx` low for cycles 1..10, then data bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high. `tx_busy` is high for exactly 100 cycles.
- `UART_TX_PARITY_EN`, push 0x07 → parity bit 1 with PARITY_ODD = 0 and 0 with PARITY_ODD = 1. Frame is 110 cycles.
- FIFO_DEPTH = 4, `s_valid` held high for 6 cycles with words 0x01..0x06:
  - 5 words accepted; `s_ready` low from edge 5; 0x06 is held until space frees.
  - Frames are emitted back-to-back with no idle cycle between stop and start.
  - `fifo_count` peaks at 4.
- DATA_BITS = 7, STOP_BITS = 2, push 0x55 → 100-cycle frame, last 20 cycles high.
- Reset asserted at cycle 35 of a frame with 3 words queued → next edge: `tx` = 1, `tx_busy` = 0, `fifo_count` = 0, `s_ready` = 1. No further frames follow.
- Push on the exact edge `tx_busy` falls → new frame starts after a one-cycle gap with correct bit timing.
